// File: rtl/risc5_hazard_scoreboard.sv
// Hazard detection and EX operand forwarding for the Risc5 pipeline, using a DEPTH-entry shift
// scoreboard. Define RISC5_FWD_EN to build the forwarding muxes; otherwise stall until write-back.
module risc5_hazard_scoreboard #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 2,
    localparam int unsigned AW      = $clog2(NREG),
    localparam int unsigned SW      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [AW-1:0]         id_rs1,
    input  logic [AW-1:0]         id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [AW-1:0]         id_rd,
    input  logic                  id_rd_we,
    input  logic                  id_is_load,
    input  logic [DEPTH*XLEN-1:0] res_data,
    output logic                  stall,
    output logic [SW-1:0]         fwd_a_sel,
    output logic [XLEN-1:0]       fwd_a_data,
    output logic [SW-1:0]         fwd_b_sel,
    output logic [XLEN-1:0]       fwd_b_data,
    output logic [31:0]           stall_cnt
);

    localparam int Depth  = int'(DEPTH);
    localparam int LdLat  = int'(LOAD_LAT);
    // A load at entry k reaches index k+1 when the ID consumer enters EX.
    localparam int LuMax  = LdLat - 2;

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] ld_q;
    logic [AW-1:0]    rd_q [DEPTH];
    logic [AW-1:0]    ex_rs1_q;
    logic [AW-1:0]    ex_rs2_q;
    logic [31:0]      stall_cnt_q;

    logic rs1_chk;
    logic rs2_chk;
    logic hazard;

    assign rs1_chk = id_rs1_used && (id_rs1 != '0);
    assign rs2_chk = id_rs2_used && (id_rs2 != '0);

    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < Depth; k++) begin
            if (v_q[k] && ((rs1_chk && (rd_q[k] == id_rs1)) ||
                           (rs2_chk && (rd_q[k] == id_rs2)))) begin
`ifdef RISC5_FWD_EN
                if (ld_q[k] && (k <= LuMax)) begin
                    hazard = 1'b1;
                end
`else
                if (k <= Depth - 2) begin
                    hazard = 1'b1;
                end
`endif
            end
        end
    end

    assign stall     = id_valid && hazard;
    assign stall_cnt = stall_cnt_q;

`ifdef RISC5_FWD_EN
    // Descending scan so the youngest qualifying producer is the last to assign.
    always_comb begin
        fwd_a_sel  = '0;
        fwd_a_data = '0;
        fwd_b_sel  = '0;
        fwd_b_data = '0;
        for (int k = Depth - 1; k >= 1; k--) begin
            if (v_q[k] && (ex_rs1_q != '0) && (rd_q[k] == ex_rs1_q) &&
                (!ld_q[k] || (k >= LdLat))) begin
                fwd_a_sel  = SW'(k);
                fwd_a_data = res_data[k*XLEN +: XLEN];
            end
            if (v_q[k] && (ex_rs2_q != '0) && (rd_q[k] == ex_rs2_q) &&
                (!ld_q[k] || (k >= LdLat))) begin
                fwd_b_sel  = SW'(k);
                fwd_b_data = res_data[k*XLEN +: XLEN];
            end
        end
    end

    // Entry 0 is the consumer itself, so its result slice is never a source.
    logic unused_res;
    assign unused_res = ^res_data[XLEN-1:0];
`else
    assign fwd_a_sel  = '0;
    assign fwd_a_data = '0;
    assign fwd_b_sel  = '0;
    assign fwd_b_data = '0;

    logic unused_nofwd;
    assign unused_nofwd = ^{res_data, ex_rs1_q, ex_rs2_q, ld_q, v_q[DEPTH-1], rd_q[DEPTH-1]};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q         <= '0;
            ld_q        <= '0;
            for (int k = 0; k < Depth; k++) begin
                rd_q[k] <= '0;
            end
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            v_q[0]  <= id_valid && id_rd_we && (id_rd != '0) && !stall;
            rd_q[0] <= id_rd;
            ld_q[0] <= id_is_load;
            for (int k = 1; k < Depth; k++) begin
                v_q[k]  <= v_q[k-1];
                rd_q[k] <= rd_q[k-1];
                ld_q[k] <= ld_q[k-1];
            end
            // Bubbles (stalled or empty slots) carry no operands into EX.
            ex_rs1_q <= (id_valid && !stall) ? id_rs1 : '0;
            ex_rs2_q <= (id_valid && !stall) ? id_rs2 : '0;
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_risc5_hazard_scoreboard.sv
// Scoreboard bench for risc5_hazard_scoreboard: a per-instruction reference model predicts each
// cycle's outputs into a queue that an independent monitor drains and compares.
module tb_risc5_hazard_scoreboard;

    localparam int XLEN     = 32;
    localparam int NREG     = 32;
    localparam int DEPTH    = 3;
    localparam int LOAD_LAT = 2;
    localparam int AW       = $clog2(NREG);
    localparam int SW       = $clog2(DEPTH);

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  id_valid;
    logic [AW-1:0]         id_rs1;
    logic [AW-1:0]         id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [AW-1:0]         id_rd;
    logic                  id_rd_we;
    logic                  id_is_load;
    logic [DEPTH*XLEN-1:0] res_data;
    logic                  stall;
    logic [SW-1:0]         fwd_a_sel;
    logic [XLEN-1:0]       fwd_a_data;
    logic [SW-1:0]         fwd_b_sel;
    logic [XLEN-1:0]       fwd_b_data;
    logic [31:0]           stall_cnt;

    always #5 clk = ~clk;

    risc5_hazard_scoreboard #(
        .XLEN     (XLEN),
        .NREG     (NREG),
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_rd_we    (id_rd_we),
        .id_is_load  (id_is_load),
        .res_data    (res_data),
        .stall       (stall),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_a_data  (fwd_a_data),
        .fwd_b_sel   (fwd_b_sel),
        .fwd_b_data  (fwd_b_data),
        .stall_cnt   (stall_cnt)
    );

    typedef struct {
        logic            stall;
        logic [SW-1:0]   a_sel;
        logic [SW-1:0]   b_sel;
        logic [XLEN-1:0] a_data;
        logic [XLEN-1:0] b_data;
        logic [31:0]     cnt;
    } exp_t;

    // An in-flight producer: the cycle it sat in EX, its destination, and whether it is a load.
    typedef struct {
        int c;
        int rd;
        bit ld;
    } rec_t;

    exp_t   expq[$];
    rec_t   recs[$];
    int     cyc;
    int     m_ex_rs1;
    int     m_ex_rs2;
    longint m_cnt;
    int     n_vec = 0;
    int     n_bad = 0;

    function automatic bit needs_stall(bit v, int s1, bit u1, int s2, bit u2);
        if (!v) return 1'b0;
        foreach (recs[i]) begin
            int k = cyc - recs[i].c;
            bit hit = (u1 && s1 != 0 && recs[i].rd == s1) || (u2 && s2 != 0 && recs[i].rd == s2);
            if (k < 0 || k > DEPTH - 1 || !hit) continue;
`ifdef RISC5_FWD_EN
            // Consumer would reach EX with the load one stage further on; data must be ready then.
            if (recs[i].ld && (k + 1 < LOAD_LAT)) return 1'b1;
`else
            // Without forwarding the consumer waits until the producer writes back.
            if (k < DEPTH - 1) return 1'b1;
`endif
        end
        return 1'b0;
    endfunction

    function automatic int best_fwd(int src);
        int best = 0;
        if (src == 0) return 0;
        foreach (recs[i]) begin
            int k = cyc - recs[i].c;
            if (k >= 1 && k <= DEPTH - 1 && recs[i].rd == src && (!recs[i].ld || k >= LOAD_LAT))
                if (best == 0 || k < best) best = k;
        end
        return best;
    endfunction

    // Apply one cycle of stimulus (called at posedge+1), predict outputs, then advance the model.
    task automatic step(input bit rst, input bit v, input int rs1, input bit u1, input int rs2,
                        input bit u2, input int rd, input bit we, input bit ld, output bit st);
        exp_t e;
        int   sa;
        int   sb;
        reset       = rst;
        id_valid    = v;
        id_rs1      = AW'(rs1);
        id_rs2      = AW'(rs2);
        id_rs1_used = u1;
        id_rs2_used = u2;
        id_rd       = AW'(rd);
        id_rd_we    = we;
        id_is_load  = ld;
        for (int i = 0; i < DEPTH; i++) res_data[i*XLEN +: XLEN] = $urandom;
        while (recs.size() > 0 && cyc - recs[0].c > DEPTH - 1) void'(recs.pop_front());
        st = needs_stall(v, rs1, u1, rs2, u2);
`ifdef RISC5_FWD_EN
        sa = best_fwd(m_ex_rs1);
        sb = best_fwd(m_ex_rs2);
`else
        sa = 0;
        sb = 0;
`endif
        e.stall  = st;
        e.a_sel  = SW'(sa);
        e.b_sel  = SW'(sb);
        e.a_data = (sa == 0) ? '0 : res_data[sa*XLEN +: XLEN];
        e.b_data = (sb == 0) ? '0 : res_data[sb*XLEN +: XLEN];
        e.cnt    = m_cnt[31:0];
        expq.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            recs.delete();
            m_ex_rs1 = 0;
            m_ex_rs2 = 0;
            m_cnt    = 0;
        end else begin
            if (st && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (v && !st && we && rd != 0) recs.push_back('{c: cyc, rd: rd, ld: ld});
            m_ex_rs1 = (v && !st) ? rs1 : 0;
            m_ex_rs2 = (v && !st) ? rs2 : 0;
        end
    endtask

    // Present an instruction in ID and hold it there until it leaves without a stall.
    task automatic issue(input int rs1, input bit u1, input int rs2, input bit u2, input int rd,
                         input bit we, input bit ld);
        bit st;
        int n = 0;
        do begin
            step(1'b0, 1'b1, rs1, u1, rs2, u2, rd, we, ld, st);
            n++;
        end while (st && n < 8);
        n_vec++;
        if (st) begin
            n_bad++;
            $display("FAIL issue_bound: still stalled after %0d cycles, required release", n);
        end
    endtask

    task automatic idle(input int n);
        bit st;
        repeat (n) step(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, st);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("stall",      32'(stall),      32'(e.stall));
            chk("fwd_a_sel",  32'(fwd_a_sel),  32'(e.a_sel));
            chk("fwd_b_sel",  32'(fwd_b_sel),  32'(e.b_sel));
            chk("fwd_a_data", fwd_a_data,      e.a_data);
            chk("fwd_b_data", fwd_b_data,      e.b_data);
            chk("stall_cnt",  stall_cnt,       e.cnt);
        end
    end

    initial begin
        bit st;
        reset       = 1'b1;
        id_valid    = 1'b0;
        id_rs1      = '0;
        id_rs2      = '0;
        id_rs1_used = 1'b0;
        id_rs2_used = 1'b0;
        id_rd       = '0;
        id_rd_we    = 1'b0;
        id_is_load  = 1'b0;
        res_data    = '0;
        cyc         = 0;
        m_ex_rs1    = 0;
        m_ex_rs2    = 0;
        m_cnt       = 0;
        repeat (2) @(posedge clk);
        #1;

        // ALU producer followed immediately by a consumer of both operands.
        issue(0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b0);
        issue(5, 1'b1, 5, 1'b1, 7, 1'b1, 1'b0);
        idle(3);
        // Load-use back to back.
        issue(0, 1'b0, 0, 1'b0, 6, 1'b1, 1'b1);
        issue(6, 1'b1, 0, 1'b1, 8, 1'b1, 1'b0);
        idle(3);
        // x0 is never tracked.
        issue(0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        issue(0, 1'b1, 0, 1'b1, 10, 1'b1, 1'b0);
        idle(3);
        // Two writers of x9; the younger must win.
        issue(0, 1'b0, 0, 1'b0, 9, 1'b1, 1'b0);
        issue(0, 1'b0, 0, 1'b0, 9, 1'b1, 1'b0);
        issue(9, 1'b1, 0, 1'b0, 11, 1'b1, 1'b0);
        idle(3);
        // Reset with a full scoreboard, then dependent readers.
        issue(0, 1'b0, 0, 1'b0, 1, 1'b1, 1'b1);
        issue(0, 1'b0, 0, 1'b0, 2, 1'b1, 1'b0);
        issue(0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b1);
        step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, st);
        issue(3, 1'b1, 2, 1'b1, 4, 1'b1, 1'b0);
        idle(3);

        // Random traffic over a small register window to provoke frequent hazards.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 4) < 2, st);
        end
        idle(2);
        @(negedge clk);
        #1;
        n_vec++;
        if (expq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
